dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Multi-cycle data-memory responder: the target end of the processor's data-memory
//  load/store interface. Accepts one word read or write request, holds it for a
//  programmable wait-state count, commits it, then returns a response under a
//  valid/ready handshake. Replaces the zero-latency dmem when wait states must be modelled.
// PARAMETERS
//  DEPTH_WORDS  64  number of 32-bit words; power of two, >= 2
//  WAIT_CYCLES  2   wait states between request accept and commit; 0..15
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-low (asserted at 0)
//  req_valid   in   1   request present
//  req_ready   out  1   request accepted this cycle when req_valid & req_ready
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address; word index = req_addr[log2(DEPTH_WORDS)+1:2]
//  req_wdata   in   32  store data
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   response consumed when rsp_valid & rsp_ready
//  rsp_rdata   out  32  load data; 0 for stores and errored requests
//  rsp_err     out  1   1 = misaligned request (req_addr[1:0] != 0)
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//    rsp_err=0, wait counter=0. Memory array is not cleared.
//  - States: IDLE, WAIT, RESP. One request outstanding at most.
//  - IDLE: req_ready=1. On req_valid, capture write/addr/wdata/misalign;
//    -> WAIT with counter=WAIT_CYCLES-1, or -> RESP directly if WAIT_CYCLES==0
//    (commit on that same edge).
//  - WAIT: req_ready=0. Decrement counter each cycle; at counter==0 commit on that edge and go -> RESP.
//  - Commit edge: store writes wdata to mem[index] unless misaligned; load
//    registers mem[index] into rsp_rdata (0 if misaligned); rsp_err registered.
//  - RESP: rsp_valid=1, req_ready=0; rsp_rdata/rsp_err stable until handshake.
//    On rsp_ready -> IDLE; rsp_valid low next cycle, rsp_rdata/rsp_err clear to 0.
//    No back-to-back accept in the handshake cycle.
//  - Latency accept->rsp_valid = WAIT_CYCLES+1 cycles; minimum 1.
//  - Addresses beyond DEPTH_WORDS*4 wrap modulo depth (upper bits ignored).
//  - Misaligned: no memory write; rsp_err=1, rsp_rdata=0; still full latency.
//  - Inputs other than req_valid are ignored outside IDLE; in IDLE only sampled on accept.
//  - Load after store to same word returns the stored value (store committed before
//    its response, so ordering is strict).
//  - Reset mid-WAIT: request discarded, store not committed. Reset in RESP: store
//    already committed and retained; response dropped.
// TESTING
//  1 Reset: hold reset=0 -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  2 WAIT_CYCLES=2: store 0xDEADBEEF @0x10, rsp_ready=1 -> rsp_valid 3 cycles after
//    accept, rsp_err=0; then load @0x10 -> rsp_rdata=0xDEADBEEF, 3-cycle latency.
//  3 Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata held,
//    req_ready=0 throughout; req_valid pulses in that window are not accepted.
//  4 Wrap: DEPTH_WORDS=64, store 0x12345678 @0x100 -> load @0x000 returns 0x12345678.
//  5 Misaligned: store 0xFFFFFFFF @0x13 -> rsp_err=1, rsp_rdata=0; load @0x10 -> prior value.
//  6 Reset mid-WAIT: store 0xA5A5A5A5 @0x20 (prior value 0x0), reset=0 in WAIT ->
//    IDLE, rsp_valid never asserts; load @0x20 returns 0x0. Repeat with WAIT_CYCLES=0 ->
//    rsp_valid 1 cycle after accept.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory responder sitting at the target end of the
// processor's load/store interface. One word request is accepted, held for
// WAIT_CYCLES wait states, committed to (or read from) the local word array,
// and the result is returned under a valid/ready handshake. At most one
// request is outstanding at any time.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  wait states between request accept and commit (0..15)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active low
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid & req_ready
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address; word index = req_addr[log2(DEPTH)+1:2]
//   req_wdata  in   store data
//   rsp_valid  out  response present
//   rsp_ready  in   response consumed when rsp_valid & rsp_ready
//   rsp_rdata  out  load data; 0 for stores and misaligned requests
//   rsp_err    out  1 = misaligned request (req_addr[1:0] != 0)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         LP_AW        = $clog2(DEPTH_WORDS);
  // Counter load value on accept; unused when there are no wait states.
  localparam logic [3:0] LP_WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam bit         LP_NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // ---------------------------------------------------------------------------
  // State and captured request
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [3:0]         r_cnt;
  logic               r_write;
  logic [LP_AW-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic               r_mis;

  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;

  logic [31:0]        r_mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Commit operands
  // ---------------------------------------------------------------------------
  // With zero wait states the commit happens on the accept edge itself, so the
  // operands come straight from the request port; otherwise they come from the
  // captured copy.
  logic               w_accept;
  logic               w_commit;
  logic               w_from_req;
  logic [LP_AW-1:0]   w_req_idx;
  logic               w_req_mis;
  logic               w_c_write;
  logic [LP_AW-1:0]   w_c_idx;
  logic [31:0]        w_c_wdata;
  logic               w_c_mis;
  logic               w_mem_we;
  logic [31:0]        w_load_data;
  logic               w_unused;

  assign w_req_idx  = req_addr[LP_AW+1:2];
  assign w_req_mis  = |req_addr[1:0];
  // Upper address bits are deliberately ignored: addresses wrap modulo depth.
  assign w_unused   = &{1'b0, req_addr[31:LP_AW+2]};

  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_commit   = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) ||
                      (LP_NO_WAIT && w_accept);

  assign w_from_req = (r_state == ST_IDLE);
  assign w_c_write  = w_from_req ? req_write : r_write;
  assign w_c_idx    = w_from_req ? w_req_idx : r_idx;
  assign w_c_wdata  = w_from_req ? req_wdata : r_wdata;
  assign w_c_mis    = w_from_req ? w_req_mis : r_mis;

  // Misaligned stores never touch the array.
  assign w_mem_we    = w_commit && w_c_write && !w_c_mis;
  assign w_load_data = (w_c_write || w_c_mis) ? 32'd0 : r_mem[w_c_idx];

  // ---------------------------------------------------------------------------
  // Word array
  // ---------------------------------------------------------------------------
  // NOTE: the array contents are intentionally not reset (a RAM has no reset);
  // the reset term only blocks writes while reset is held, so a request seen in
  // reset can never land in memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
    end else if (w_mem_we) begin
      r_mem[w_c_idx] <= w_c_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment so all state moves
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_mis       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_idx       <= w_req_idx;
            r_wdata     <= req_wdata;
            r_mis       <= w_req_mis;
            r_req_ready <= 1'b0;
            if (LP_NO_WAIT) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_load_data;
              r_rsp_err   <= w_c_mis;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= LP_WAIT_INIT;
            end
          end
        end

        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_load_data;
            r_rsp_err   <= w_c_mis;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_RESP: begin
          // Handshake returns to IDLE; the next request is taken at the
          // earliest on the following edge.
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'd0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders share clock and reset: u0 with two wait states, u1 with none.
// A transaction-level model (busy flag, age since accept, word array) predicts
// every output on every falling edge; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int NI    = 2;
  localparam int DEPTH = 64;

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_write [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model
  // ---------------------------------------------------------------------------
  bit          m_busy  [NI];
  int          m_age   [NI];   // edges since accept, accept edge counts as 1
  bit          m_wr    [NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_wdata [NI];
  logic [31:0] m_rdata [NI];
  bit          m_err   [NI];
  logic [31:0] m_mem   [NI][DEPTH];

  task automatic m_commit(input int i);
    int idx;
    idx = int'((m_addr[i] >> 2) % DEPTH);
    m_err[i] = (m_addr[i] % 4) != 0;
    if (m_err[i]) begin
      m_rdata[i] = 32'd0;
    end else if (m_wr[i]) begin
      m_mem[i][idx] = m_wdata[i];
      m_rdata[i]    = 32'd0;
    end else begin
      m_rdata[i] = m_mem[i][idx];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          m_busy[i] = 1'b0;
        end else if (m_busy[i] && m_age[i] >= wc(i) + 1) begin
          if (rsp_ready[i]) m_busy[i] = 1'b0;
        end else if (m_busy[i]) begin
          m_age[i]++;
          if (m_age[i] == wc(i) + 1) m_commit(i);
        end else if (req_valid[i]) begin
          m_busy[i]  = 1'b1;
          m_age[i]   = 1;
          m_wr[i]    = req_write[i];
          m_addr[i]  = req_addr[i];
          m_wdata[i] = req_wdata[i];
          if (m_age[i] == wc(i) + 1) m_commit(i);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        logic        e_rdy, e_vld, e_err;
        logic [31:0] e_dat;
        if (!m_busy[i]) begin
          e_rdy = 1'b1; e_vld = 1'b0; e_dat = 32'd0; e_err = 1'b0;
        end else if (m_age[i] < wc(i) + 1) begin
          e_rdy = 1'b0; e_vld = 1'b0; e_dat = 32'd0; e_err = 1'b0;
        end else begin
          e_rdy = 1'b0; e_vld = 1'b1; e_dat = m_rdata[i]; e_err = m_err[i];
        end
        check($sformatf("u%0d req_ready", i), 32'(req_ready[i]), 32'(e_rdy));
        check($sformatf("u%0d rsp_valid", i), 32'(rsp_valid[i]), 32'(e_vld));
        check($sformatf("u%0d rsp_rdata", i), rsp_rdata[i], e_dat);
        check($sformatf("u%0d rsp_err", i), 32'(rsp_err[i]), 32'(e_err));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: call at posedge+1; returns at posedge+1 after the handshake edge.
  // ---------------------------------------------------------------------------
  task automatic send(input int i, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input int bp, input bit pulse,
                      output logic [31:0] rdata, output logic err, output int lat);
    bit acc, got, done;
    int nvalid;
    rdata = 32'd0; err = 1'b0; lat = 0;
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready[i];
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
    req_write[i] = 1'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    if (!acc) begin
      check($sformatf("u%0d accept timeout", i), 32'd0, 32'd1);
      return;
    end
    rsp_ready[i] = (bp == 0);
    got = 1'b0; done = 1'b0; nvalid = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin
        if (!got) begin
          got = 1'b1; lat = k; rdata = rsp_rdata[i]; err = rsp_err[i];
        end
        nvalid++;
        if (rsp_ready[i]) done = 1'b1;
      end
      @(posedge clk); #1;
      if (got && nvalid >= bp) begin
        rsp_ready[i] = 1'b1;
        req_valid[i] = 1'b0;
      end else if (pulse && got) begin
        req_valid[i] = 1'($urandom);
      end
    end
    req_valid[i] = 1'b0;
    rsp_ready[i] = 1'b0;
    if (!done) check($sformatf("u%0d response timeout", i), 32'd0, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd, a;
    logic        er;
    int          lt;
    bit          seen;

    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'd0;
      req_wdata[i] = 32'd0; rsp_ready[i] = 1'b0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d reset req_ready", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("u%0d reset rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      check($sformatf("u%0d reset rsp_rdata", i), rsp_rdata[i], 32'd0);
      check($sformatf("u%0d reset rsp_err", i), 32'(rsp_err[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Give every word a known value
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < DEPTH; w++)
        send(i, 1'b1, 32'(w * 4), $urandom, 0, 1'b0, rd, er, lt);

    // Store then load, three-cycle latency
    send(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er, lt);
    check("store latency", 32'(lt), 32'd3);
    check("store err", 32'(er), 32'd0);
    check("store rdata", rd, 32'd0);
    send(0, 1'b0, 32'h10, 32'd0, 0, 1'b0, rd, er, lt);
    check("load rdata", rd, 32'hDEADBEEF);
    check("load latency", 32'(lt), 32'd3);
    check("model word4", m_mem[0][4], 32'hDEADBEEF);

    // Backpressure with request pulses during the response window
    send(0, 1'b0, 32'h10, 32'd0, 5, 1'b1, rd, er, lt);
    check("bp load rdata", rd, 32'hDEADBEEF);

    // Address wrap
    send(0, 1'b1, 32'h100, 32'h12345678, 0, 1'b0, rd, er, lt);
    send(0, 1'b0, 32'h000, 32'd0, 0, 1'b0, rd, er, lt);
    check("wrap load", rd, 32'h12345678);

    // Misaligned store
    send(0, 1'b1, 32'h13, 32'hFFFFFFFF, 0, 1'b0, rd, er, lt);
    check("misaligned err", 32'(er), 32'd1);
    check("misaligned rdata", rd, 32'd0);
    check("misaligned latency", 32'(lt), 32'd3);
    send(0, 1'b0, 32'h10, 32'd0, 0, 1'b0, rd, er, lt);
    check("after misaligned load", rd, 32'hDEADBEEF);

    // Reset during WAIT discards the store
    send(0, 1'b1, 32'h20, 32'h0, 0, 1'b0, rd, er, lt);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hA5A5A5A5;
    @(negedge clk);
    check("mid-wait accept ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #3 rst_n = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = 1'b1;
    end
    check("mid-wait no rsp_valid", 32'(seen), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 1'b0, 32'h20, 32'd0, 0, 1'b0, rd, er, lt);
    check("mid-wait store dropped", rd, 32'h0);

    // Reset during RESP keeps the committed store
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h24; req_wdata[0] = 32'h0BADF00D;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = rsp_valid[0];
    end
    check("resp-reset reached RESP", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 1'b0, 32'h24, 32'd0, 0, 1'b0, rd, er, lt);
    check("resp-reset store kept", rd, 32'h0BADF00D);

    // Zero wait states
    send(1, 1'b1, 32'h20, 32'hA5A5A5A5, 0, 1'b0, rd, er, lt);
    check("w0 store latency", 32'(lt), 32'd1);
    send(1, 1'b0, 32'h20, 32'd0, 2, 1'b1, rd, er, lt);
    check("w0 load rdata", rd, 32'hA5A5A5A5);
    check("w0 load latency", 32'(lt), 32'd1);

    // Randomized traffic on both instances
    for (int n = 0; n < 160; n++) begin
      int i;
      i = n % NI;
      a = $urandom;
      if ($urandom_range(7) != 0) a[1:0] = 2'b00;
      send(i, 1'($urandom), a, $urandom, int'($urandom_range(3)),
           1'($urandom), rd, er, lt);
      check($sformatf("u%0d rand latency", i), 32'(lt), 32'(wc(i) + 1));
      check($sformatf("u%0d rand err", i), 32'(er), 32'(a[1:0] != 2'b00));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
